serial_parity_checker: RTL and testbench

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

---
 rtl/serial_parity_pkg.sv | 31 +++
 rtl/serial_parity_checker.sv | 158 +++++++++++++++
 tb/tb_serial_parity_checker.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_pkg.sv
// -----------------------------------------------------------------------------
// serial_parity_pkg
//
// Shared definitions for the serial parity checker:
//   state_e       - receiver FSM states (IDLE, DATA, PARITY, STOP)
//   EVEN / ODD    - parity-mode constants for the ODD_PARITY parameter
//   ERR_CNT_W     - width of the errored-frame counter
//   ERR_CNT_MAX   - saturation value of the errored-frame counter
//   bitcnt_width  - width of the data-bit index for a given frame size
// -----------------------------------------------------------------------------
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam int EVEN = 0;
    localparam int ODD  = 1;

    localparam int             ERR_CNT_W   = 8;
    localparam logic [7:0]     ERR_CNT_MAX = 8'hFF;

    // A 1-bit frame still needs a 1-bit counter, so clamp $clog2 at 1.
    function automatic int bitcnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : serial_parity_pkg

// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//
// Receives frames on a one-bit-per-clock serial line:
//   start bit (0), DATA_W data bits LSB first, one parity bit, one stop bit (1).
// The line idles high. Each completed frame produces a one-cycle valid pulse
// with the received word and its parity / framing error flags; these hold
// until the next frame completes.
//
// Parameters:
//   DATA_W      data bits per frame (1..32)
//   ODD_PARITY  0 = even parity (EVEN), 1 = odd parity (ODD)
//
// Ports:
//   clock       in   1       single clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   x           in   1       serial line, idle high
//   data        out  DATA_W  received word
//   valid       out  1       one-cycle pulse: frame complete, data/flags valid
//   parity_err  out  1       parity mismatch for the frame flagged by valid
//   frame_err   out  1       stop bit sampled low for the frame flagged by valid
//   err_cnt     out  8       saturating count of errored frames
//
// Configuration macro:
//   SERIAL_PARITY_CHECKER_ERR_CNT_EN
//     defined   - err_cnt counts frames delivered with parity_err or
//                 frame_err set, saturating at 255.
//     undefined - err_cnt is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = EVEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    localparam int   CNT_W   = bitcnt_width(DATA_W);
    localparam logic ODD_BIT = (ODD_PARITY != EVEN);

    // Receiver state
    state_e             state_q;
    logic [CNT_W-1:0]   bitcnt_q;
    logic [CNT_W-1:0]   bitcnt_d;
    logic               par_q;
    logic               par_d;
    logic [DATA_W-1:0]  shift_q;
    logic               perr_pend_q;

    // Registered outputs
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               perr_q;
    logic               ferr_q;

    logic               last_bit;
    logic               parity_mismatch;

    assign bitcnt_d        = bitcnt_q + CNT_W'(1);
    assign par_d           = par_q ^ x;
    assign last_bit        = (bitcnt_q == CNT_W'(DATA_W - 1));
    // par_d in PARITY is the XOR of all data bits and the parity bit.
    assign parity_mismatch = (par_d != ODD_BIT);

    // -------------------------------------------------------------------------
    // Receiver FSM. The assembled word lives in shift_q while the frame is in
    // flight and is copied to data_q only at STOP, so the output word and
    // flags stay stable between valid pulses.
    // STOP always returns to IDLE: a low stop bit is reported as a framing
    // error, never reused as the next start bit. IDLE can accept a start bit
    // in the valid cycle, so frames may arrive back to back.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            par_q       <= 1'b0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!x) begin
                        state_q  <= DATA;
                        bitcnt_q <= '0;
                        par_q    <= 1'b0;
                    end
                end
                DATA: begin
                    shift_q[bitcnt_q] <= x;
                    par_q             <= par_d;
                    if (last_bit) begin
                        state_q <= PARITY;
                    end else begin
                        bitcnt_q <= bitcnt_d;
                    end
                end
                PARITY: begin
                    perr_pend_q <= parity_mismatch;
                    state_q     <= STOP;
                end
                STOP: begin
                    data_q  <= shift_q;
                    perr_q  <= perr_pend_q;
                    ferr_q  <= ~x;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    // Errored-frame counter. It updates on the STOP edge, the same edge that
    // raises valid, so the new count is visible in the valid cycle.
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic                 stop_err;

    assign stop_err  = (state_q == STOP) && (perr_pend_q || !x);
    assign err_cnt_d = (stop_err && (err_cnt_q != ERR_CNT_MAX))
                       ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule : serial_parity_checker

// File: tb/tb_serial_parity_checker.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_checker
//
// Self-checking bench for serial_parity_checker (DATA_W=8, even parity).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Every frame the bench expects to complete is pushed onto
// exp_q; a monitor pops one entry per valid pulse and checks word, flags,
// err_cnt and start-to-valid latency, and checks that outputs hold between
// pulses.
// -----------------------------------------------------------------------------
module tb_serial_parity_checker;

  localparam int DATA_W = 8;
  localparam int ODD_P  = 0;
  localparam int LAT    = DATA_W + 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              x     = 1'b1;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic [7:0]        err_cnt;

  serial_parity_checker #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_P)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .x          (x),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  // ---------------------------------------------------------------- clock
  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              perr;
    logic              ferr;
    logic [7:0]        cnt;
    int                start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   vedge_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: parity error when the count of ones over data+parity bit does
  // not have the configured parity.
  function automatic logic model_perr(input logic [DATA_W-1:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) != ODD_P);
  endfunction

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.d    = d;
    e.perr = perr;
    e.ferr = ferr;
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    if ((perr || ferr) && model_cnt < 255) model_cnt++;
    e.cnt = 8'(model_cnt);
`else
    e.cnt = 8'd0;
`endif
    e.start_edge = edge_n;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_bit(input logic b);
    x = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                            input logic perr, input logic ferr);
    drive_bit(1'b0);
    push_exp(d, perr, ferr);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    x = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      drive_bit(1'b1);
      k++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------- monitor
  exp_t              mon_e;
  logic [DATA_W-1:0] held_d   = '0;
  logic              held_pe  = 1'b0;
  logic              held_fe  = 1'b0;
  logic [7:0]        held_cnt = 8'd0;
  logic              prev_valid = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      held_d     = '0;
      held_pe    = 1'b0;
      held_fe    = 1'b0;
      held_cnt   = 8'd0;
      prev_valid = 1'b0;
    end else if (valid) begin
      check("valid_single_cycle", prev_valid, 1'b0);
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data", data, mon_e.d);
        check("parity_err", parity_err, mon_e.perr);
        check("frame_err", frame_err, mon_e.ferr);
        check("err_cnt", err_cnt, mon_e.cnt);
        check("latency", edge_n - mon_e.start_edge + 1, LAT);
        held_d   = mon_e.d;
        held_pe  = mon_e.perr;
        held_fe  = mon_e.ferr;
        held_cnt = mon_e.cnt;
      end
      vedge_q.push_back(edge_n);
      prev_valid = 1'b1;
    end else begin
      check("hold_data", data, held_d);
      check("hold_parity_err", parity_err, held_pe);
      check("hold_frame_err", frame_err, held_fe);
      check("hold_err_cnt", err_cnt, held_cnt);
      prev_valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              p;
    logic              s;
    logic              perr;
    logic              ferr;
  } vec_t;

  vec_t vecs[8];

  // ---------------------------------------------------------------- test
  initial begin
    logic [DATA_W-1:0] rd;
    logic              rp;
    logic              rs;
    int                gap;

    // {data, parity bit, stop bit, expected parity_err, expected frame_err}
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    reset = 1'b1;
    x     = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    // Table: sent back to back
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].perr, vecs[i].ferr);
    end
    drain(20);
    idle(3);

    // Low stop bit must not start a frame: line stays high, nothing arrives,
    // then a normal frame is received with the usual latency.
    vedge_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(15);
    check("stop_low_valid_count", vedge_q.size(), 1);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(20);
    idle(2);

    // Back-to-back pair: pulses exactly one frame length apart
    vedge_q.delete();
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(20);
    check("b2b_valid_count", vedge_q.size(), 2);
    if (vedge_q.size() == 2) check("b2b_spacing", vedge_q[1] - vedge_q[0], LAT);
    idle(2);

    // Reset after the 4th data bit aborts the frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    reset     = 1'b1;
    model_cnt = 0;
    @(negedge clock);
    check("abort_data", data, 0);
    check("abort_valid", valid, 0);
    check("abort_parity_err", parity_err, 0);
    check("abort_frame_err", frame_err, 0);
    check("abort_err_cnt", err_cnt, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(20);

    // Random frames against the reference model
    for (int i = 0; i < 200; i++) begin
      rd  = DATA_W'($urandom_range(0, 255));
      rp  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 2);
      send_frame(rd, rp, rs, model_perr(rd, rp), !rs);
      idle(gap);
    end
    drain(20);

    // Errored frames to push the counter into saturation
    for (int i = 0; i < 300; i++) begin
      rd = DATA_W'($urandom_range(0, 255));
      rp = 1'b0;
      if (!model_perr(rd, 1'b0)) rp = 1'b1;
      send_frame(rd, rp, 1'b1, 1'b1, 1'b0);
    end
    drain(20);
    @(negedge clock);
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    check("err_cnt_saturated", err_cnt, 8'd255);
`else
    check("err_cnt_tied_zero", err_cnt, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_parity_checker
